// File: rtl/fsvid2axis_if.sv
// rtl/fsvid2axis_if.sv - AXI4-Stream video bus with master/slave views
interface fsvid2axis_if #(
  parameter int C_DATA_WIDTH = 8
);
  logic                    tvalid;
  logic                    tready;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic                    tuser;
  logic                    tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/fsvid2axis.sv
// rtl/fsvid2axis.sv - parallel video timing to AXI4-Stream video with frame measurement
module fsvid2axis #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_IMG_WBITS  = 12,
  parameter int C_IMG_HBITS  = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    vid_active_video,
  input  logic                    vid_vblank,
  input  logic [C_DATA_WIDTH-1:0] vid_data,
  fsvid2axis_if.master            m_axis,
  output logic [C_IMG_WBITS-1:0]  frame_width,
  output logic [C_IMG_HBITS-1:0]  frame_height,
  output logic [31:0]             frame_cnt,
  output logic                    overflow
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(C_FIFO_DEPTH);

  typedef enum logic [1:0] {S_SYNC, S_ARMED, S_ACTIVE, S_DROP} state_t;
  state_t state, state_nx;

  logic                    vblank_q;
  logic                    hold_valid, hold_sof, hold_last;
  logic [C_DATA_WIDTH-1:0] hold_data;
  logic [C_DATA_WIDTH+1:0] mem [C_FIFO_DEPTH];
  logic [C_DATA_WIDTH+1:0] rd_word;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count, count_after;
  logic [C_IMG_WBITS-1:0]  pix_cnt;
  logic [C_IMG_HBITS-1:0]  line_tally;
  logic                    prev_px;

  logic px_in, vb_rise, rd_en, slot_avail, accepting;
  logic wr_en, wr_last, take, drop_px, frame_end, new_line;

  assign px_in       = vid_active_video & ~vid_vblank;
  assign vb_rise     = vid_vblank & ~vblank_q;
  assign rd_en       = m_axis.tvalid & m_axis.tready;
  // Space is judged after this edge's read so a full FIFO can still accept while draining.
  assign count_after = count - (AW+1)'(rd_en);
  assign slot_avail  = count_after < DEPTH_L;
  assign accepting   = (state == S_ARMED) || (state == S_ACTIVE);
  assign wr_en       = hold_valid & slot_avail;
  assign take        = px_in & accepting & (~hold_valid | slot_avail);
  assign drop_px     = px_in & accepting & hold_valid & ~slot_avail;
  assign wr_last     = hold_last | ~((state == S_ACTIVE) & px_in);
  assign frame_end   = (state == S_ACTIVE) & vb_rise;
  assign new_line    = take & (~prev_px | (state == S_ARMED));

  assign rd_word        = mem[rd_ptr];
  assign m_axis.tvalid  = (count != '0);
  assign m_axis.tdata   = m_axis.tvalid ? rd_word[C_DATA_WIDTH-1:0] : '0;
  assign m_axis.tuser   = m_axis.tvalid & rd_word[C_DATA_WIDTH];
  assign m_axis.tlast   = m_axis.tvalid & rd_word[C_DATA_WIDTH+1];

  always_comb begin
    state_nx = state;
    case (state)
      S_SYNC:   if (vid_vblank) state_nx = S_ARMED;
      S_ARMED:  if (take) state_nx = S_ACTIVE;
                else if (drop_px) state_nx = S_DROP;
      S_ACTIVE: if (vb_rise) state_nx = S_ARMED;
                else if (drop_px) state_nx = S_DROP;
      S_DROP:   if (vb_rise) state_nx = S_ARMED;
      default:  state_nx = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_SYNC;
      vblank_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      vblank_q <= vid_vblank;
      if (drop_px) overflow <= 1'b1;
    end
  end

  // A held pixel that cannot be written stays pending and is forced to end its line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_sof   <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
    end else if (take) begin
      hold_valid <= 1'b1;
      hold_sof   <= (state == S_ARMED);
      hold_last  <= 1'b0;
      hold_data  <= vid_data;
    end else if (wr_en) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
    end else if (hold_valid) begin
      hold_last  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_last, hold_sof, hold_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt      <= '0;
      line_tally   <= '0;
      prev_px      <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_cnt    <= '0;
    end else begin
      prev_px <= take;
      if (take) begin
        if (new_line) pix_cnt <= C_IMG_WBITS'(1);
        else if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
        if (state == S_ARMED) line_tally <= C_IMG_HBITS'(1);
        else if (new_line && line_tally != '1) line_tally <= line_tally + 1'b1;
      end
      if (frame_end) begin
        frame_width  <= pix_cnt;
        frame_height <= line_tally;
        frame_cnt    <= frame_cnt + 1'b1;
      end
    end
  end
endmodule
